mod_seq_unit: RTL and testbench

- Parametrised sequential modulo/division unit. It merges the control FSM with its own datapath and computes remainder and quotient of A / B.
- Start/ready/done handshake. Divide-by-zero is detected.
- Default algorithm is repeated subtraction. An optional restoring shift-subtract mode gives fixed latency.
- Instantiated by top-level arithmetic blocks as a multi-cycle functional unit.

---
 rtl/mod_pkg.sv | 12 +
 rtl/mod_seq_unit_if.sv | 34 +++
 rtl/mod_dp.sv | 117 +++++++++++
 rtl/mod_seq_unit.sv | 111 +++++++++++
 tb/tb_mod_seq_unit.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/mod_pkg.sv
// Shared definitions for the sequential divide/modulo unit: FSM state encoding.
package mod_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mod_seq_unit_if.sv
// Start/ready/done bus of the divide/modulo unit. The master drives the operands
// and the request, and the slave (the unit) returns the status, results and FSM state.
interface mod_seq_unit_if #(
  parameter int WIDTH = 8
);
  import mod_pkg::*;

  // Handshake:
  // - A request is accepted on a rising edge where start=1 and ready=1, and
  //   a_in/b_in are captured on that edge. start while ready=0 is dropped.
  // - done is a one-cycle pulse. remainder, quotient and div_by_zero are valid
  //   from that cycle and hold until the next done.
  // - ready rises in the cycle after the done pulse.
  logic               start;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               ready;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   remainder;
  logic [WIDTH-1:0]   quotient;
  logic               div_by_zero;
  logic [STATE_W-1:0] dbg_state;

  modport master (
    output start, a_in, b_in,
    input  ready, busy, done, remainder, quotient, div_by_zero, dbg_state
  );

  modport slave (
    input  start, a_in, b_in,
    output ready, busy, done, remainder, quotient, div_by_zero, dbg_state
  );
endinterface

// File: rtl/mod_dp.sv
// Datapath of the divide/modulo unit: operand/quotient registers, subtractor, result registers.
// MOD_SHIFT_SUB_EN selects restoring shift-subtract; otherwise repeated subtraction.
module mod_dp #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             load_zero_i,
  input  logic             step_i,
  input  logic             finish_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ge_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic             dbz_o
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             dbz_q, dbz_d;
  logic             ge;

`ifdef MOD_SHIFT_SUB_EN
  // a_q is the dividend shifted out MSB first into the partial remainder p_q.
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH:0]   p_sh;
  logic [WIDTH-1:0] p_nx;
  logic [WIDTH-1:0] q_nx;
`endif

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    q_d   = q_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dbz_d = dbz_q;
`ifdef MOD_SHIFT_SUB_EN
    p_d  = p_q;
    p_sh = {p_q, a_q[WIDTH-1]};
    ge   = (p_sh >= {1'b0, b_q});
    p_nx = ge ? WIDTH'(p_sh - {1'b0, b_q}) : p_sh[WIDTH-1:0];
    q_nx = {q_q[WIDTH-2:0], ge};
`else
    ge   = (a_q >= b_q);
`endif

    if (load_i) begin
      a_d   = a_i;
      b_d   = b_i;
      q_d   = '0;
      dbz_d = 1'b0;
`ifdef MOD_SHIFT_SUB_EN
      p_d   = '0;
`endif
    end else if (load_zero_i) begin
      rem_d = a_i;
      quo_d = '1;
      dbz_d = 1'b1;
    end else if (step_i) begin
`ifdef MOD_SHIFT_SUB_EN
      p_d = p_nx;
      a_d = {a_q[WIDTH-2:0], 1'b0};
      q_d = q_nx;
`else
      a_d = a_q - b_q;
      q_d = q_q + WIDTH'(1);
`endif
    end

    // In shift mode the last step and the result capture share one edge.
    if (finish_i) begin
`ifdef MOD_SHIFT_SUB_EN
      rem_d = p_nx;
      quo_d = q_nx;
`else
      rem_d = a_q;
      quo_d = q_q;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      q_q   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dbz_q <= 1'b0;
`ifdef MOD_SHIFT_SUB_EN
      p_q   <= '0;
`endif
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      q_q   <= q_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dbz_q <= dbz_d;
`ifdef MOD_SHIFT_SUB_EN
      p_q   <= p_d;
`endif
    end
  end

  assign ge_o        = ge;
  assign remainder_o = rem_q;
  assign quotient_o  = quo_q;
  assign dbz_o       = dbz_q;

endmodule

// File: rtl/mod_seq_unit.sv
// Sequential divide/modulo unit: control FSM around mod_dp.
// MOD_SHIFT_SUB_EN gives fixed-latency restoring division; undefined gives repeated subtraction.
module mod_seq_unit
  import mod_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic          CLK,
  input logic          reset,
  mod_seq_unit_if.slave bus
);

  state_e state_q, state_d;
  logic   ready_q, busy_q, done_q;
  logic   load, load_zero, step, finish;
  logic   ge;

`ifdef MOD_SHIFT_SUB_EN
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_zero = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
`ifdef MOD_SHIFT_SUB_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start && ready_q) begin
          if (bus.b_in != '0) begin
            load    = 1'b1;
            state_d = SUB;
`ifdef MOD_SHIFT_SUB_EN
            cnt_d   = '0;
`endif
          end else begin
            load_zero = 1'b1;
            state_d   = DONE;
          end
        end
      end
      SUB: begin
`ifdef MOD_SHIFT_SUB_EN
        step  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          finish  = 1'b1;
          state_d = DONE;
        end
`else
        if (ge) begin
          step = 1'b1;
        end else begin
          finish  = 1'b1;
          state_d = DONE;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // done trails DONE by one cycle; ready stays low through that pulse.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MOD_SHIFT_SUB_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DONE);
      ready_q <= (state_d == IDLE) && (state_q != DONE);
      busy_q  <= (state_d != IDLE) || (state_q == DONE);
`ifdef MOD_SHIFT_SUB_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  mod_dp #(.WIDTH(WIDTH)) u_dp (
    .clk_i       (CLK),
    .rst_i       (reset),
    .load_i      (load),
    .load_zero_i (load_zero),
    .step_i      (step),
    .finish_i    (finish),
    .a_i         (bus.a_in),
    .b_i         (bus.b_in),
    .ge_o        (ge),
    .remainder_o (bus.remainder),
    .quotient_o  (bus.quotient),
    .dbz_o       (bus.div_by_zero)
  );

  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mod_seq_unit.sv
// Self-checking bench for mod_seq_unit (WIDTH=8); honours MOD_SHIFT_SUB_EN for latency.
module tb_mod_seq_unit;
  import mod_pkg::*;

  localparam int W = 8;
`ifdef MOD_SHIFT_SUB_EN
  localparam bit SHIFT = 1'b1;
`else
  localparam bit SHIFT = 1'b0;
`endif

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  mod_seq_unit_if #(.WIDTH(W)) bus ();

  mod_seq_unit #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  logic [2*W:0] exp_q[$];
  int           lat_q[$];
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return 1;
    if (SHIFT) return W + 1;
    return int'(a / b) + 2;
  endfunction

  // Drive one accepted request; ends at the negedge after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    logic [2*W:0] e;
    if (push) begin
      if (b == '0) e = {1'b1, a, {W{1'b1}}};
      else         e = {1'b0, a % b, a / b};
      exp_q.push_back(e);
      lat_q.push_back(exp_lat(a, b));
    end
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    @(posedge CLK);
    #1 bus.start = 1'b0;
    @(negedge CLK);
    check("busy_after_start", bus.busy, 1);
    check("ready_after_start", bus.ready, 0);
  endtask

  // Wait for done (pre = edges already elapsed since the accepting edge), pop and compare.
  task automatic wait_done(input int pre);
    int           cnt;
    bit           seen;
    logic [2*W:0] e;
    int           l;
    cnt  = pre;
    seen = 1'b0;
    while (!seen && cnt < 600) begin
      @(posedge CLK);
      cnt++;
      @(negedge CLK);
      if (bus.done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    if (exp_q.size() == 0) begin
      check("sb_underflow", 0, 1);
    end else begin
      e = exp_q.pop_front();
      l = lat_q.pop_front();
      check("latency", cnt, l);
      check("remainder", bus.remainder, e[2*W-1:W]);
      check("quotient", bus.quotient, e[W-1:0]);
      check("div_by_zero", bus.div_by_zero, e[2*W]);
      check("ready_in_done", bus.ready, 0);
    end
    @(negedge CLK);
    check("done_one_cycle", bus.done, 0);
    check("ready_after_done", bus.ready, 1);
    check("busy_after_done", bus.busy, 0);
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_ready", bus.ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rem", bus.remainder, 0);
    check("rst_quo", bus.quotient, 0);
    check("rst_dbz", bus.div_by_zero, 0);
    check("rst_state", bus.dbg_state, IDLE);
    reset = 1'b0;

    // Basic divisions.
    start_op(8'd17, 8'd5, 1'b1); wait_done(0);
    start_op(8'd3, 8'd7, 1'b1);  wait_done(0);

    // Divide by zero, then hold, then a normal op clears the flag.
    start_op(8'd200, 8'd0, 1'b1); wait_done(0);
    repeat (3) @(negedge CLK);
    check("dbz_held", bus.div_by_zero, 1);
    check("rem_held", bus.remainder, 200);
    start_op(8'd200, 8'd4, 1'b1);
    check("dbz_cleared_on_start", bus.div_by_zero, 0);
    check("rem_kept_on_start", bus.remainder, 200);
    check("quo_kept_on_start", bus.quotient, 255);
    wait_done(0);

    // Reset mid-operation aborts without done.
    start_op(8'd100, 8'd3, 1'b0);
    repeat (3) begin
      @(negedge CLK);
      check("no_done_before_rst", bus.done, 0);
    end
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    check("abort_ready", bus.ready, 1);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_rem", bus.remainder, 0);
    check("abort_quo", bus.quotient, 0);
    check("abort_dbz", bus.div_by_zero, 0);
    check("abort_state", bus.dbg_state, IDLE);
    repeat (2) begin
      @(negedge CLK);
      check("no_done_after_rst", bus.done, 0);
    end

    // Largest quotient.
    start_op(8'd255, 8'd1, 1'b1); wait_done(0);

    // A start while busy is dropped.
    start_op(8'd50, 8'd7, 1'b1);
    bus.a_in  = 8'd9;
    bus.b_in  = 8'd2;
    bus.start = 1'b1;
    check("ready_low_busy", bus.ready, 0);
    @(posedge CLK);
    #1 bus.start = 1'b0;
    wait_done(1);

    // Random operands, including occasional zero divisor.
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 40));
      start_op(ra, rb, 1'b1);
      wait_done(0);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
